// File: rtl/arb_mux_pkg.sv
// arb_mux_pkg
//   Shared types and default sizes for the 2:1 arbitrated merge (arb_mux_2to1)
//   and its grant sub-module (rr_arb2).
//   src_t   : origin tag of a merged word (SRC_A = 0, SRC_B = 1)
//   state_t : output register occupancy (EMPTY / FULL)
package arb_mux_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_CNT_W = 16;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
//   Two-requester grant logic for arb_mux_2to1.
//   Optional feature macro: ARB_MUX_RR_EN
//     defined   : on contention, grant the requester not served last; the
//                 last-served pointer moves on every accepted word (advance).
//     undefined : fixed priority, A always wins; no pointer state exists.
//   Ports:
//     clk, rst_n     : clock, asynchronous active-low reset (pointer only)
//     req_a, req_b   : requests (source valids)
//     advance        : a granted word was accepted this cycle
//     gnt_a, gnt_b   : one-hot-or-zero grants, combinational
module rr_arb2
  import arb_mux_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_a,
  input  logic req_b,
  input  logic advance,
  output logic gnt_a,
  output logic gnt_b
);

`ifdef ARB_MUX_RR_EN
  src_t last_q;

  // Pointer resets to B so that A wins the first contended cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= SRC_B;
    end else if (advance) begin
      last_q <= gnt_b ? SRC_B : SRC_A;
    end
  end

  always_comb begin
    gnt_a = req_a && (!req_b || (last_q == SRC_B));
    gnt_b = req_b && (!req_a || (last_q == SRC_A));
  end
`else
  // Fixed priority: clock, reset and advance only drive the pointer,
  // which this build does not have.
  logic unused_ports;
  assign unused_ports = ^{clk, rst_n, advance};

  always_comb begin
    gnt_a = req_a;
    gnt_b = req_b && !req_a;
  end
`endif

endmodule

// File: rtl/arb_mux_2to1.sv
// arb_mux_2to1
//   Merges two valid/ready sources (A, B) into one registered valid/ready
//   output through a one-entry output register. Throughput 1 word/cycle,
//   latency 1. Counts accepted words per source (wrapping counters).
//   Optional feature macro: ARB_MUX_RR_EN (round-robin instead of A-priority,
//   implemented inside rr_arb2).
//   Ports:
//     clk, rst_n              : clock, asynchronous active-low reset
//     a_data/a_valid/a_ready  : source A handshake
//     b_data/b_valid/b_ready  : source B handshake
//     y_data/y_valid/y_ready  : merged output handshake (registered data/valid)
//     y_src                   : origin of y_data (0 = A, 1 = B)
//     cnt_a, cnt_b            : words accepted from A / B
module arb_mux_2to1
  import arb_mux_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_valid,
  output logic             b_ready,
  output logic [WIDTH-1:0] y_data,
  output logic             y_valid,
  input  logic             y_ready,
  output logic             y_src,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  state_t           state_q;
  src_t             src_q;
  logic [WIDTH-1:0] data_q;
  logic [CNT_W-1:0] cnt_a_q;
  logic [CNT_W-1:0] cnt_b_q;

  logic load_en;
  logic gnt_a;
  logic gnt_b;
  logic acc_a;
  logic acc_b;

  // The register can take a word when empty or when its current word leaves
  // this cycle. y_ready only reaches the readies, never y_data.
  always_comb begin
    load_en = (state_q == EMPTY) || ((state_q == FULL) && y_ready);
  end

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_a   (a_valid),
    .req_b   (b_valid),
    .advance (acc_a || acc_b),
    .gnt_a   (gnt_a),
    .gnt_b   (gnt_b)
  );

  // rst_n gating keeps both readies low during reset even though the
  // register reads as EMPTY then.
  always_comb begin
    acc_a   = rst_n && load_en && gnt_a;
    acc_b   = rst_n && load_en && gnt_b;
    a_ready = acc_a;
    b_ready = acc_b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      src_q   <= SRC_A;
      data_q  <= '0;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      if (acc_a) begin
        state_q <= FULL;
        src_q   <= SRC_A;
        data_q  <= a_data;
        cnt_a_q <= cnt_a_q + 1'b1;
      end else if (acc_b) begin
        state_q <= FULL;
        src_q   <= SRC_B;
        data_q  <= b_data;
        cnt_b_q <= cnt_b_q + 1'b1;
      end else if ((state_q == FULL) && y_ready) begin
        state_q <= EMPTY;
      end
    end
  end

  assign y_valid = (state_q == FULL);
  assign y_data  = data_q;
  assign y_src   = src_q;
  assign cnt_a   = cnt_a_q;
  assign cnt_b   = cnt_b_q;

endmodule

// File: tb/tb_arb_mux_2to1.sv
module tb_arb_mux_2to1;

`ifdef ARB_MUX_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [7:0]  a_data;
  logic        a_valid;
  logic        a_ready;
  logic [7:0]  b_data;
  logic        b_valid;
  logic        b_ready;
  logic [7:0]  y_data;
  logic        y_valid;
  logic        y_ready;
  logic        y_src;
  logic [15:0] cnt_a;
  logic [15:0] cnt_b;

  int checks   = 0;
  int failures = 0;

  logic [15:0] ea;
  logic [15:0] eb;
  logic [7:0]  hold_data;
  logic        hold_src;
  logic        exp_b;

  arb_mux_2to1 #(.WIDTH(8), .CNT_W(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_data  (a_data),
    .a_valid (a_valid),
    .a_ready (a_ready),
    .b_data  (b_data),
    .b_valid (b_valid),
    .b_ready (b_ready),
    .y_data  (y_data),
    .y_valid (y_valid),
    .y_ready (y_ready),
    .y_src   (y_src),
    .cnt_a   (cnt_a),
    .cnt_b   (cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n   = 1'b0;
    a_valid = 1'b1;
    b_valid = 1'b1;
    a_data  = 8'h77;
    b_data  = 8'h88;
    y_ready = 1'b0;
    ea      = '0;
    eb      = '0;

    // Reset state, readies gated although both sources request
    #12;
    chk("rst_a_ready", 32'(a_ready), 32'd0);
    chk("rst_b_ready", 32'(b_ready), 32'd0);
    chk("rst_y_valid", 32'(y_valid), 32'd0);
    chk("rst_y_data",  32'(y_data),  32'd0);
    chk("rst_y_src",   32'(y_src),   32'd0);
    chk("rst_cnt_a",   32'(cnt_a),   32'd0);
    chk("rst_cnt_b",   32'(cnt_b),   32'd0);

    // First word right after release
    b_valid = 1'b0;
    rst_n   = 1'b1;
    a_valid = 1'b1;
    a_data  = 8'h11;
    y_ready = 1'b1;
    #1;
    chk("first_a_ready", 32'(a_ready), 32'd1);
    chk("first_b_ready", 32'(b_ready), 32'd0);
    edge1();
    ea++;
    chk("first_y_valid", 32'(y_valid), 32'd1);
    chk("first_y_data",  32'(y_data),  32'h11);
    chk("first_y_src",   32'(y_src),   32'd0);
    chk("first_cnt_a",   32'(cnt_a),   32'(ea));

    // No valid: no grant; then drain to EMPTY
    a_valid = 1'b0;
    #1;
    chk("idle_a_ready", 32'(a_ready), 32'd0);
    chk("idle_b_ready", 32'(b_ready), 32'd0);
    edge1();
    chk("drain_y_valid", 32'(y_valid), 32'd0);

    // B alone
    b_valid = 1'b1;
    b_data  = 8'h5C;
    #1;
    chk("bonly_b_ready", 32'(b_ready), 32'd1);
    chk("bonly_a_ready", 32'(a_ready), 32'd0);
    edge1();
    eb++;
    chk("bonly_y_data", 32'(y_data), 32'h5C);
    chk("bonly_y_src",  32'(y_src),  32'd1);
    chk("bonly_cnt_b",  32'(cnt_b),  32'(eb));
    b_valid = 1'b0;
    edge1();
    chk("bonly_drain", 32'(y_valid), 32'd0);

    // Both valid, continuous: RR alternates A,B,...; fixed priority always A
    a_valid = 1'b1;
    b_valid = 1'b1;
    a_data  = 8'hA0;
    b_data  = 8'hB0;
    for (int i = 0; i < 6; i++) begin
      exp_b = RR && (i % 2 == 1);
      #1;
      chk("both_a_ready", 32'(a_ready), 32'(!exp_b));
      chk("both_b_ready", 32'(b_ready), 32'(exp_b));
      @(posedge clk);
      #1;
      if (exp_b) eb++; else ea++;
      chk("both_y_valid", 32'(y_valid), 32'd1);
      chk("both_y_data",  32'(y_data),  exp_b ? 32'hB0 : 32'hA0);
      chk("both_y_src",   32'(y_src),   32'(exp_b));
      chk("both_cnt_a",   32'(cnt_a),   32'(ea));
      chk("both_cnt_b",   32'(cnt_b),   32'(eb));
    end

    // Stall: FULL, y_ready low, both valid -> nothing accepted, output held
    hold_data = RR ? 8'hB0 : 8'hA0;
    hold_src  = RR;
    y_ready   = 1'b0;
    a_data    = 8'hA1;
    b_data    = 8'hB1;
    repeat (5) begin
      #1;
      chk("stall_a_ready", 32'(a_ready), 32'd0);
      chk("stall_b_ready", 32'(b_ready), 32'd0);
      edge1();
      chk("stall_y_valid", 32'(y_valid), 32'd1);
      chk("stall_y_data",  32'(y_data),  32'(hold_data));
      chk("stall_y_src",   32'(y_src),   32'(hold_src));
    end
    chk("stall_cnt_a", 32'(cnt_a), 32'(ea));
    chk("stall_cnt_b", 32'(cnt_b), 32'(eb));

    // Release: drain and load in the same cycle (A wins in both builds here)
    y_ready = 1'b1;
    #1;
    chk("rel_a_ready", 32'(a_ready), 32'd1);
    chk("rel_b_ready", 32'(b_ready), 32'd0);
    edge1();
    ea++;
    chk("rel_y_valid", 32'(y_valid), 32'd1);
    chk("rel_y_data",  32'(y_data),  32'hA1);
    chk("rel_y_src",   32'(y_src),   32'd0);
    chk("rel_cnt_a",   32'(cnt_a),   32'(ea));

    // Counter wrap: run A to 0xFFFF, then one more word
    b_valid = 1'b0;
    a_data  = 8'h42;
    while (ea != 16'hFFFF) begin
      @(posedge clk);
      ea++;
    end
    #1;
    chk("pre_wrap_cnt_a", 32'(cnt_a), 32'h0000FFFF);
    edge1();
    ea++;
    chk("wrap_cnt_a", 32'(cnt_a), 32'h0);
    chk("wrap_cnt_b", 32'(cnt_b), 32'(eb));
    chk("wrap_y_valid", 32'(y_valid), 32'd1);

    // Asynchronous reset mid-stream while the register is FULL
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_y_valid", 32'(y_valid), 32'd0);
    chk("arst_y_data",  32'(y_data),  32'd0);
    chk("arst_cnt_a",   32'(cnt_a),   32'd0);
    chk("arst_cnt_b",   32'(cnt_b),   32'd0);
    chk("arst_a_ready", 32'(a_ready), 32'd0);
    edge1();
    chk("arst_hold_y_valid", 32'(y_valid), 32'd0);

    // Resume: pointer back at B, so A wins contention in both builds
    a_data  = 8'h3C;
    b_data  = 8'hC3;
    b_valid = 1'b1;
    rst_n   = 1'b1;
    #1;
    chk("resume_a_ready", 32'(a_ready), 32'd1);
    chk("resume_b_ready", 32'(b_ready), 32'd0);
    edge1();
    chk("resume_y_data", 32'(y_data), 32'h3C);
    chk("resume_y_src",  32'(y_src),  32'd0);
    chk("resume_cnt_a",  32'(cnt_a),  32'd1);
    chk("resume_cnt_b",  32'(cnt_b),  32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
